// File: rtl/lock_pkg.sv
// Shared definitions for the lockout controller: the controller state
// encoding, default timing/threshold constants and a small helper used
// to size the shared cycle timer.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } lock_state_t;

    localparam int DEF_MAX_FAIL       = 3;
    localparam int DEF_OPEN_CYCLES    = 8;
    localparam int DEF_LOCKOUT_CYCLES = 16;
    localparam int FAIL_CNT_W         = 4;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT phases. A load
// strobe places N-1 into the counter; it then counts down once per cycle
// and parks at zero, where the expired flag is raised. It never wraps.
module cycle_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadVal,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    // Count down toward zero, reloading on request and holding at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/lockout_controller.sv
// Door lockout controller sitting behind a password lock. Correct codes
// open the door for a fixed time; a run of wrong entries locks the panel
// out for a fixed time and raises a one-cycle alarm. All outputs are
// registered, so each response appears one cycle after its input.
module lockout_controller
    import lock_pkg::*;
#(
    parameter int MAX_FAIL       = DEF_MAX_FAIL,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  unlock_in,
    input  logic                  error_in,
    output logic                  entry_en,
    output logic                  door_open,
    output logic                  locked_out,
    output logic                  alarm,
    output logic [FAIL_CNT_W-1:0] fail_cnt
);

    localparam int TIMER_W = $clog2(maxInt(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);
    localparam logic [TIMER_W-1:0]    OPEN_LOAD    = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_CNT_W-1:0] FAIL_LIMIT   = FAIL_CNT_W'(MAX_FAIL);

    lock_state_t r_state;
    lock_state_t w_stateNext;

    logic [FAIL_CNT_W-1:0] r_failCnt;
    logic [FAIL_CNT_W-1:0] w_failNext;
    logic [FAIL_CNT_W-1:0] w_failInc;

    logic               r_entryEn;
    logic               r_doorOpen;
    logic               r_lockedOut;
    logic               r_alarm;
    logic               w_alarmNext;
    logic               w_load;
    logic [TIMER_W-1:0] w_loadVal;
    logic               w_expired;

    assign w_failInc = r_failCnt + 1'b1;

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_loadVal (w_loadVal),
        .o_expired (w_expired)
    );

    // State and failure-count register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_failCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_failCnt <= w_failNext;
        end
    end

    // Next-state decode; an error always beats a simultaneous unlock and
    // the timed states ignore both inputs until the timer runs out.
    always_comb begin
        w_stateNext = r_state;
        w_failNext  = r_failCnt;
        w_alarmNext = 1'b0;
        w_load      = 1'b0;
        w_loadVal   = '0;
        case (r_state)
            IDLE: begin
                if (error_in) begin
                    if (w_failInc >= FAIL_LIMIT) begin
                        w_stateNext = LOCKOUT;
                        w_failNext  = '0;
                        w_alarmNext = 1'b1;
                        w_load      = 1'b1;
                        w_loadVal   = LOCKOUT_LOAD;
                    end else begin
                        w_failNext = w_failInc;
                    end
                end else if (unlock_in) begin
                    w_stateNext = OPEN;
                    w_failNext  = '0;
                    w_load      = 1'b1;
                    w_loadVal   = OPEN_LOAD;
                end
            end
            OPEN: begin
                if (w_expired) begin
                    w_stateNext = IDLE;
                end
            end
            LOCKOUT: begin
                if (w_expired) begin
                    w_stateNext = IDLE;
                    w_failNext  = '0;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_failNext  = '0;
            end
        endcase
    end

    // Register the outputs from the upcoming state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_entryEn   <= 1'b1;
            r_doorOpen  <= 1'b0;
            r_lockedOut <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_entryEn   <= (w_stateNext == IDLE);
            r_doorOpen  <= (w_stateNext == OPEN);
            r_lockedOut <= (w_stateNext == LOCKOUT);
            r_alarm     <= w_alarmNext;
        end
    end

    assign entry_en   = r_entryEn;
    assign door_open  = r_doorOpen;
    assign locked_out = r_lockedOut;
    assign alarm      = r_alarm;
    assign fail_cnt   = r_failCnt;

endmodule

// File: tb/tb_lockout_controller.sv
// Directed bench for the lockout controller with default parameters
// (3 failures, 8 open cycles, 16 lockout cycles).
module tb_lockout_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       unlock_in = 1'b0;
    logic       error_in = 1'b0;
    logic       entry_en;
    logic       door_open;
    logic       locked_out;
    logic       alarm;
    logic [3:0] fail_cnt;

    int vectors = 0;
    int miscompares = 0;

    lockout_controller #(
        .MAX_FAIL       (3),
        .OPEN_CYCLES    (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .unlock_in  (unlock_in),
        .error_in   (error_in),
        .entry_en   (entry_en),
        .door_open  (door_open),
        .locked_out (locked_out),
        .alarm      (alarm),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock them in, then release them.
    task automatic applyStimulus(input logic u, input logic e);
        unlock_in = u;
        error_in  = e;
        @(posedge clk);
        #1;
        unlock_in = 1'b0;
        error_in  = 1'b0;
    endtask

    // Compare all outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic expEntry,
                               input logic expDoor, input logic expLocked,
                               input logic expAlarm, input logic [3:0] expFail);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {entry_en, door_open, locked_out, alarm, fail_cnt};
        exp = {expEntry, expDoor, expLocked, expAlarm, expFail};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed entry/door/lock/alarm/cnt=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset", 1, 0, 0, 0, 4'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle_after_reset", 1, 0, 0, 0, 4'd0);

        // Single unlock: door open exactly 8 cycles
        applyStimulus(1'b1, 1'b0);
        checkOutput("open_c1", 0, 1, 0, 0, 4'd0);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("open_c%0d", i), 0, 1, 0, 0, 4'd0);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("open_done", 1, 0, 0, 0, 4'd0);

        // Three spaced errors lead to lockout
        applyStimulus(1'b0, 1'b1);
        checkOutput("err1", 1, 0, 0, 0, 4'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("err1_hold", 1, 0, 0, 0, 4'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("err2", 1, 0, 0, 0, 4'd2);
        applyStimulus(1'b0, 1'b0);
        checkOutput("err2_hold", 1, 0, 0, 0, 4'd2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lock_c1_alarm", 0, 0, 1, 1, 4'd0);
        for (int i = 2; i <= 16; i++) begin
            applyStimulus((i == 4), (i == 7));
            checkOutput($sformatf("lock_c%0d", i), 0, 0, 1, 0, 4'd0);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("lock_expiry_ignored", 1, 0, 0, 0, 4'd0);

        // Two errors then unlock clears the count
        applyStimulus(1'b0, 1'b1);
        checkOutput("e1", 1, 0, 0, 0, 4'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("e2", 1, 0, 0, 0, 4'd2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("unlock_clears", 0, 1, 0, 0, 4'd0);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus((i == 3), (i == 5));
            checkOutput($sformatf("open2_c%0d", i), 0, 1, 0, 0, 4'd0);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("open_expiry_ignored", 1, 0, 0, 0, 4'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("err_after_open", 1, 0, 0, 0, 4'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("no_lockout", 1, 0, 0, 0, 4'd1);

        // Simultaneous unlock and error count as errors
        applyStimulus(1'b1, 1'b1);
        checkOutput("both_is_error", 1, 0, 0, 0, 4'd2);
        applyStimulus(1'b1, 1'b1);
        checkOutput("both_to_lockout", 0, 0, 1, 1, 4'd0);

        // Reset on cycle 5 of lockout, with an input present
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("lock3_c%0d", i), 0, 0, 1, 0, 4'd0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset_in_lockout", 1, 0, 0, 0, 4'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("after_lock_reset", 1, 0, 0, 0, 4'd0);

        // Reset during open beats both inputs
        applyStimulus(1'b1, 1'b0);
        checkOutput("open3_c1", 0, 1, 0, 0, 4'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("open3_c2", 0, 1, 0, 0, 4'd0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset_in_open", 1, 0, 0, 0, 4'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("after_open_reset", 1, 0, 0, 0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lockout_controller.md
LOCKOUT_CONTROLLER -- requirements
Module: lockout_controller

Interface
REQ-001 Parameter MAX_FAIL, default 3: consecutive failed attempts that trigger lockout; legal range 1..15.
REQ-002 Parameter OPEN_CYCLES, default 8: door_open high time in clk cycles; legal range >=1.
REQ-003 Parameter LOCKOUT_CYCLES, default 16: locked_out high time in clk cycles; legal range >=1.
REQ-004 clk  input  1  clock; all logic rising-edge triggered.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 unlock_in  input  1  single-cycle pulse: correct code accepted by the upstream password lock.
REQ-007 error_in  input  1  single-cycle pulse: wrong bit entered at the upstream password lock.
REQ-008 entry_en  output  1  high when the upstream lock may accept enter strobes; upstream gates enter with it.
REQ-009 door_open  output  1  door relay drive.
REQ-010 locked_out  output  1  lockout active.
REQ-011 alarm  output  1  single-cycle pulse on lockout entry.
REQ-012 fail_cnt  output  4  current consecutive-failure count.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, OPEN, LOCKOUT.
REQ-014 All outputs SHALL be registered; each response appears on the first edge after the input is sampled (latency 1 cycle).
REQ-015 entry_en SHALL be 1 in IDLE only; door_open 1 in OPEN only; locked_out 1 in LOCKOUT only.
REQ-016 IDLE, unlock_in=1, error_in=0: go to OPEN, clear fail_cnt, load timer for OPEN_CYCLES.
REQ-017 IDLE, error_in=1, fail_cnt+1 < MAX_FAIL: stay in IDLE, increment fail_cnt.
REQ-018 IDLE, error_in=1, fail_cnt+1 = MAX_FAIL: go to LOCKOUT, clear fail_cnt, pulse alarm for one cycle, load timer for LOCKOUT_CYCLES.
REQ-019 IDLE, unlock_in and error_in both 1: error_in SHALL win and unlock_in is discarded.
REQ-020 OPEN: door_open SHALL stay high for exactly OPEN_CYCLES cycles, then return to IDLE; unlock_in/error_in ignored.
REQ-021 LOCKOUT: locked_out SHALL stay high for exactly LOCKOUT_CYCLES cycles, then return to IDLE with fail_cnt=0; inputs ignored.
REQ-022 The timer SHALL be a down-counter of width $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1) loaded with N-1; expiry occurs when the count is 0 in OPEN/LOCKOUT; no wrap-around permitted.
REQ-023 fail_cnt SHALL never exceed MAX_FAIL-1 while in IDLE.
REQ-024 Inputs arriving on the cycle of the timer-expiry return to IDLE SHALL be ignored; the first input evaluated is on the cycle after entry_en rises.

Reset
REQ-025 rst=0 at a rising edge SHALL force IDLE, fail_cnt=0, timer=0, door_open=0, locked_out=0, alarm=0, entry_en=1.
REQ-026 Reset asserted during OPEN or LOCKOUT SHALL abort the state immediately, with no residual pulse after release.
REQ-027 Reset SHALL take priority over every input, including simultaneous unlock_in/error_in.

Structure
REQ-028 Shared package lock_pkg SHALL hold the state enum (IDLE/OPEN/LOCKOUT) and default constants for MAX_FAIL, OPEN_CYCLES and LOCKOUT_CYCLES.
REQ-029 One sub-module, cycle_timer (load value, load strobe, expired flag), SHALL serve both OPEN and LOCKOUT timing.
REQ-030 Implementation target: 120-400 lines of RTL in total.

Verification
REQ-031 Single unlock_in pulse from IDLE -> door_open high exactly 8 cycles starting 1 cycle later, entry_en low for the same 8 cycles, fail_cnt=0.
REQ-032 Three error_in pulses spaced 2 cycles apart -> fail_cnt 1, 2, then alarm for 1 cycle, locked_out high 16 cycles, fail_cnt=0.
REQ-033 Two errors then unlock_in -> fail_cnt returns to 0 and door opens; next error -> fail_cnt=1 with no lockout.
REQ-034 unlock_in and error_in high in the same IDLE cycle -> treated as an error; door_open stays 0 and fail_cnt increments.
REQ-035 rst=0 on cycle 5 of LOCKOUT -> next cycle IDLE, locked_out=0, entry_en=1, no alarm pulse.
REQ-036 unlock_in/error_in pulsed during OPEN, during LOCKOUT, and on the expiry cycle -> no state or fail_cnt change.
